// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-read-port, dual-write-port register file for the MIPS
//            datapath, with optional hardwired zero register, same-cycle
//            write-to-read bypass and a sequenced clear engine that zeroes
//            one entry per cycle while holding ready low.
// Ports    : clk, reset             - clock, synchronous active-high reset
//            rd_addr_i / rd_data_o  - packed read ports (combinational data)
//            we0_i/waddr0_i/wdata0_i- write port 0 (ALU / load writeback)
//            we1_i/waddr1_i/wdata1_i- write port 1 (retire), wins over port 0
//            clear_req_i            - one-cycle request to re-zero the file
//            ready_o                - file accepts writes, returns stored data
//            wr_drop_o              - pulse one cycle after a discarded write
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data_o,
  input  logic                           we0_i,
  input  logic [ADDR_WIDTH-1:0]          waddr0_i,
  input  logic [DATA_WIDTH-1:0]          wdata0_i,
  input  logic                           we1_i,
  input  logic [ADDR_WIDTH-1:0]          waddr1_i,
  input  logic [DATA_WIDTH-1:0]          wdata1_i,
  input  logic                           clear_req_i,
  output logic                           ready_o,
  output logic                           wr_drop_o
);

  localparam int                    DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX = '1;  // DEPTH-1
  localparam logic [ADDR_WIDTH-1:0] c_ZERO_IDX = '0;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  wr_drop_q, wr_drop_d;
  logic                  clr_we, wen0, wen1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Next-state logic and write qualification.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_drop_d = 1'b0;
    clr_we    = 1'b0;
    wen0      = 1'b0;
    wen1      = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we    = 1'b1;
        cnt_d     = cnt_q + 1'b1;          // wraps to 0 after the last entry
        wr_drop_d = we0_i | we1_i;
        if (cnt_q == c_LAST_IDX) begin
          state_d = S_READY;
        end
      end
      default: begin
        // Port 1 owns a shared address; port 0 is masked rather than
        // relying on assignment order inside the memory process.
        wen1 = we1_i && !(ZERO_REG && (waddr1_i == c_ZERO_IDX));
        wen0 = we0_i && !(ZERO_REG && (waddr0_i == c_ZERO_IDX))
                     && !(we1_i && (waddr1_i == waddr0_i));
        if (clear_req_i) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Storage has no reset of its own; the clear engine zeroes it after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_we) mem_q[cnt_q]    <= '0;
      if (wen0)   mem_q[waddr0_i] <= wdata0_i;
      if (wen1)   mem_q[waddr1_i] <= wdata1_i;
    end
  end

  assign ready_o   = (state_q == S_READY);
  assign wr_drop_o = wr_drop_q;

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;

    assign addr = rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      data = mem_q[addr];
      if (state_q == S_CLEAR) begin
        data = '0;
      end else if (ZERO_REG && (addr == c_ZERO_IDX)) begin
        data = '0;
      end else if (BYPASS && we1_i && (waddr1_i == addr)) begin
        data = wdata1_i;
      end else if (BYPASS && we0_i && (waddr0_i == addr)) begin
        data = wdata0_i;
      end
    end

    assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = data;
  end

endmodule
`default_nettype wire
